multicycle_controller: RTL

- Next-generation multi-cycle control FSM for the philv core. It sequences fetch, decode, execute, memory and writeback for R-type, I-type, load, store and conditional-branch instructions.
- Unlike the first-generation controller, it stalls on instruction- and data-memory ready handshakes and bounds each stall with a timeout.
- Unknown opcodes and timeouts trap into a sticky fault state; retired instructions are counted.
- Sits between the instruction register (opCode) and the datapath muxes, register file, PC and data memory.

---
 rtl/multicycle_controller.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the philv core.
// Sequences fetch, decode, execute, memory and writeback, and stalls on the
// instruction and data memory ready handshakes. Each stall is bounded by a timeout.
// Illegal opcodes and timeouts trap into a sticky fault state.
// Retired instructions are counted.
module multicycle_controller #(
    parameter int unsigned OPCODE_WIDTH     = 7,
    parameter int unsigned TIMEOUT_CYCLES   = 16,
    parameter int unsigned RETIRE_CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [OPCODE_WIDTH-1:0]     opCode,
    input  logic                        imemReady,
    input  logic                        dmemReady,
    input  logic                        branchTaken,
    output logic                        PCWrite,
    output logic                        PCWriteCond,
    output logic                        IRWrite,
    output logic                        DMemRead,
    output logic                        DMemWrite,
    output logic                        ALUOverride,
    output logic                        ALUSrcA,
    output logic [1:0]                  ALUSrcB,
    output logic                        regFileWrite,
    output logic                        regFileWriteSrc,
    output logic                        fault,
    output logic [1:0]                  faultCause,
    output logic [RETIRE_CNT_WIDTH-1:0] retireCount,
    output logic [3:0]                  state
);

    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    localparam logic [OPCODE_WIDTH-1:0] OpR     = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OpImm   = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OpLoad  = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OpStore = OPCODE_WIDTH'(7'b0100011);
    localparam logic [OPCODE_WIDTH-1:0] OpBr    = OPCODE_WIDTH'(7'b1100011);

    localparam logic [1:0] CauseIllegal = 2'd1;
    localparam logic [1:0] CauseImem    = 2'd2;
    localparam logic [1:0] CauseDmem    = 2'd3;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StExecI    = 4'd3,
        StExecB    = 4'd4,
        StMemLoad  = 4'd5,
        StMemStore = 4'd6,
        StWb       = 4'd7,
        StWbMem    = 4'd8,
        StTrap     = 4'd15
    } state_e;

    state_e                      state_q, state_d;
    logic [WaitW-1:0]            wait_q;
    logic                        fault_q;
    logic [1:0]                  cause_q, trap_cause;
    logic [RETIRE_CNT_WIDTH-1:0] retire_q;
    logic                        wait_last;
    logic                        waiting;
    logic                        retire;

    assign wait_last = (wait_q == WaitLast);

    // Cycles that are stalled on a memory handshake advance the timeout counter.
    assign waiting = ((state_q == StFetch) && !imemReady) ||
                     (((state_q == StMemLoad) || (state_q == StMemStore)) && !dmemReady);

    // An instruction retires only when one of its final states returns to fetch.
    assign retire = (state_d == StFetch) &&
                    ((state_q == StExecB) || (state_q == StMemStore) ||
                     (state_q == StWb) || (state_q == StWbMem));

    // Next-state selection and the cause recorded on entry to TRAP.
    always_comb begin
        state_d    = state_q;
        trap_cause = 2'd0;
        case (state_q)
            StFetch: begin
                if (imemReady) begin
                    state_d = StDecode;
                end else if (wait_last) begin
                    state_d    = StTrap;
                    trap_cause = CauseImem;
                end
            end
            StDecode: begin
                if (opCode == OpR) begin
                    state_d = StExecR;
                end else if ((opCode == OpImm) || (opCode == OpLoad) || (opCode == OpStore)) begin
                    state_d = StExecI;
                end else if (opCode == OpBr) begin
                    state_d = StExecB;
                end else begin
                    state_d    = StTrap;
                    trap_cause = CauseIllegal;
                end
            end
            StExecR: state_d = StWb;
            StExecI: begin
                if (opCode == OpLoad) begin
                    state_d = StMemLoad;
                end else if (opCode == OpStore) begin
                    state_d = StMemStore;
                end else if (opCode == OpImm) begin
                    state_d = StWb;
                end else begin
                    // The instruction register changed under us; treat it as illegal.
                    state_d    = StTrap;
                    trap_cause = CauseIllegal;
                end
            end
            StExecB: state_d = StFetch;
            StMemLoad: begin
                if (dmemReady) begin
                    state_d = StWbMem;
                end else if (wait_last) begin
                    state_d    = StTrap;
                    trap_cause = CauseDmem;
                end
            end
            StMemStore: begin
                if (dmemReady) begin
                    state_d = StFetch;
                end else if (wait_last) begin
                    state_d    = StTrap;
                    trap_cause = CauseDmem;
                end
            end
            StWb:    state_d = StFetch;
            StWbMem: state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: begin
                state_d    = StTrap;
                trap_cause = CauseIllegal;
            end
        endcase
    end

    // State, wait counter, sticky fault and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StFetch;
            wait_q   <= '0;
            fault_q  <= 1'b0;
            cause_q  <= 2'd0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (waiting) begin
                wait_q <= wait_q + WaitW'(1);
            end
            if ((state_d == StTrap) && (state_q != StTrap)) begin
                fault_q <= 1'b1;
                cause_q <= trap_cause;
            end
            if (retire) begin
                retire_q <= retire_q + RETIRE_CNT_WIDTH'(1);
            end
        end
    end

    // Moore output decode; IRWrite additionally qualifies on imemReady in FETCH.
    always_comb begin
        PCWrite         = 1'b0;
        PCWriteCond     = 1'b0;
        IRWrite         = 1'b0;
        DMemRead        = 1'b0;
        DMemWrite       = 1'b0;
        ALUOverride     = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'd0;
        regFileWrite    = 1'b0;
        regFileWriteSrc = 1'b0;
        case (state_q)
            StFetch: begin
                ALUOverride = 1'b1;
                ALUSrcB     = 2'd2;
                IRWrite     = imemReady;
            end
            StDecode:   PCWrite = 1'b1;
            StExecR:    ALUSrcA = 1'b1;
            StExecI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd1;
            end
            StExecB: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
            end
            StMemLoad:  DMemRead = 1'b1;
            StMemStore: DMemWrite = 1'b1;
            StWb:       regFileWrite = 1'b1;
            StWbMem: begin
                regFileWrite    = 1'b1;
                regFileWriteSrc = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault       = fault_q;
    assign faultCause  = cause_q;
    assign retireCount = retire_q;
    assign state       = state_q;

endmodule
